// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per execution unit, one registered broadcast per cycle.
// Optional round-robin arbitration is enabled by defining CDB_ARB_RR_EN; the default is fixed priority.
package cdb_pkg;

  typedef struct packed {
    logic [4:0]  rob_idx;
    logic [5:0]  pd;
    logic [31:0] pv;
    logic [31:0] pc_next;
    logic        regf_we;
    logic        update_pc_next;
    logic        branch_taken;
  } execution_out_t;

  typedef struct packed {
    logic [4:0]  rob_idx;
    logic [5:0]  pd;
    logic [31:0] pv;
    logic [31:0] pc_next;
    logic        regf_we;
    logic        update_pc_next;
    logic        branch_taken;
  } CDB_t;

  function automatic CDB_t to_cdb(input execution_out_t e);
    CDB_t c;
    c.rob_idx        = e.rob_idx;
    c.pd             = e.pd;
    c.pv             = e.pv;
    c.pc_next        = e.pc_next;
    c.regf_we        = e.regf_we;
    c.update_pc_next = e.update_pc_next;
    c.branch_taken   = e.branch_taken;
    return c;
  endfunction

endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  execution_out_t [NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          cdb_valid,
  output CDB_t                          cdb_out,
  output logic [IDX_W-1:0]              grant_idx
);

  logic [NUM_REQ-1:0]           slot_valid_q, slot_valid_d;
  execution_out_t [NUM_REQ-1:0] slot_data_q, slot_data_d;
  logic                         cdb_valid_q, cdb_valid_d;
  CDB_t                         cdb_out_q, cdb_out_d;
  logic [IDX_W-1:0]             grant_idx_q, grant_idx_d;

  logic [NUM_REQ-1:0]           grant;
  logic                         gnt_any;
  logic [IDX_W-1:0]             gnt_idx;

`ifdef CDB_ARB_RR_EN
  logic [IDX_W-1:0]             rr_ptr_q, rr_ptr_d;
  int unsigned                  cand;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!gnt_any && !flush && slot_valid_q[cand[IDX_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) rr_ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!gnt_any && !flush && slot_valid_q[k[IDX_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = k[IDX_W-1:0];
      end
    end
  end
`endif

  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant[i] = gnt_any && (gnt_idx == i[IDX_W-1:0]);
    end
  end

  // A granted slot frees up in the same cycle, which lets a unit refill it without a bubble.
  always_comb begin
    req_ready = ~slot_valid_q | grant;
  end

  always_comb begin
    slot_valid_d = slot_valid_q & ~grant;
    slot_data_d  = slot_data_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i] && !flush) begin
        slot_valid_d[i] = 1'b1;
        slot_data_d[i]  = req_data[i];
      end
    end
    if (flush) slot_valid_d = '0;

    cdb_valid_d = gnt_any;
    cdb_out_d   = gnt_any ? to_cdb(slot_data_q[gnt_idx]) : cdb_out_q;
    grant_idx_d = gnt_any ? gnt_idx : grant_idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_q <= '0;
      slot_data_q  <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_out_q    <= '0;
      grant_idx_q  <= '0;
`ifdef CDB_ARB_RR_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_data_q  <= slot_data_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_out_q    <= cdb_out_d;
      grant_idx_q  <= grant_idx_d;
`ifdef CDB_ARB_RR_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_out   = cdb_out_q;
  assign grant_idx = grant_idx_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_grant_onehot0: assert ($onehot0(grant));
      a_grant_full:    assert ((grant & ~slot_valid_q) == '0);
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (slot_valid_q[i] && !grant[i] && !flush) begin
          a_slot_stable: assert (slot_valid_d[i] && (slot_data_d[i] == slot_data_q[i]));
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts are queued at drive time and matched on cdb_valid.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         flush;
  logic [NUM_REQ-1:0]           req_valid;
  execution_out_t [NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         cdb_valid;
  CDB_t                         cdb_out;
  logic [IDX_W-1:0]             grant_idx;

  cdb_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_out   (cdb_out),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]     idx;
    execution_out_t d;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_r0, exp_r3;

  function automatic execution_out_t mk(input logic [5:0] pd, input logic [31:0] pv);
    execution_out_t e;
    e.rob_idx        = pd[4:0] ^ 5'h15;
    e.pd             = pd;
    e.pv             = pv;
    e.pc_next        = ~pv;
    e.regf_we        = pv[0];
    e.update_pc_next = pv[1];
    e.branch_taken   = pv[2];
    return e;
  endfunction

  function automatic logic [127:0] exp_vec(input logic [1:0] idx, input execution_out_t e);
    return 128'({idx, e.rob_idx, e.pd, e.pv, e.pc_next, e.regf_we, e.update_pc_next, e.branch_taken});
  endfunction

  function automatic logic [127:0] obs_vec(input logic [1:0] idx, input CDB_t c);
    return 128'({idx, c.rob_idx, c.pd, c.pv, c.pc_next, c.regf_we, c.update_pc_next, c.branch_taken});
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [1:0] idx, input execution_out_t d);
    exp_t e;
    e.idx = idx;
    e.d   = d;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int unsigned n = 0;
    while (sb.size() != 0 && n < 30) begin
      cyc();
      n++;
    end
    n_checks++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL %s: observed %0d pending broadcasts expected 0", tag, sb.size());
    end
    cyc();
  endtask

  // Fill all four slots in one cycle, then expect broadcasts first, first+1, ... on consecutive cycles.
  task automatic all4(input string tag, input logic [1:0] first, input logic [7:0] base);
    logic [1:0] g;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) req_data[i] = mk(6'(base) + 6'(i), {base, 24'(i)});
    for (int k = 0; k < 4; k++) begin
      g = first + 2'(k);
      push(g, req_data[g]);
    end
    @(negedge clk);
    chk({tag, "_ready_fill"}, 128'(req_ready), 128'(4'hF));
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk({tag, "_lat1_valid"}, 128'(cdb_valid), 128'(1'b0));
    chk({tag, "_lat1_ready"}, 128'(req_ready), 128'(4'b0001 << first));
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      chk({tag, "_valid"}, 128'(cdb_valid), 128'(1'b1));
      chk({tag, "_idx"}, 128'(grant_idx), 128'(first + 2'(k)));
    end
    cyc();
    @(negedge clk);
    chk({tag, "_end"}, 128'(cdb_valid), 128'(1'b0));
    cyc();
  endtask

  always @(negedge clk) begin
    if (cdb_valid === 1'b1) begin
      n_checks++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL cdb_unexpected: observed broadcast idx %0d pv %0h expected none", grant_idx, cdb_out.pv);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("cdb_payload", obs_vec(grant_idx, cdb_out), exp_vec(mon_e.idx, mon_e.d));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed no end of test expected completion within 50000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    repeat (3) cyc();
    rst = 1'b0;

    // Reset state held through idle cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_valid", 128'(cdb_valid), 128'(1'b0));
      chk("idle_idx", 128'(grant_idx), 128'(2'd0));
      chk("idle_ready", 128'(req_ready), 128'(4'hF));
      if (i == 0) chk("rst_cdb_out", 128'(cdb_out), 128'(0));
      cyc();
    end

    // Single request from MUL: broadcast two edges after drive
    req_valid   = 4'b0010;
    req_data[1] = mk(6'd12, 32'hDEADBEEF);
    push(2'd1, req_data[1]);
    @(negedge clk);
    chk("single_ready_c0", 128'(req_ready), 128'(4'hF));
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk("single_valid_c1", 128'(cdb_valid), 128'(1'b0));
    chk("single_ready_c1", 128'(req_ready), 128'(4'hF));
    cyc();
    @(negedge clk);
    chk("single_valid_c2", 128'(cdb_valid), 128'(1'b1));
    chk("single_idx", 128'(grant_idx), 128'(2'd1));
    chk("single_pd", 128'(cdb_out.pd), 128'(6'd12));
    chk("single_pv", 128'(cdb_out.pv), 128'(32'hDEADBEEF));
    cyc();
    @(negedge clk);
    chk("single_valid_c3", 128'(cdb_valid), 128'(1'b0));
    cyc();

`ifdef CDB_ARB_RR_EN
    all4("all4", 2'd2, 8'hA0);
`else
    all4("all4", 2'd0, 8'hA0);
`endif

    // Back-to-back ALU results through the same-cycle grant/refill path
    for (int k = 1; k <= 5; k++) begin
      req_valid   = 4'b0001;
      req_data[0] = mk(6'd1, 32'(k));
      push(2'd0, req_data[0]);
      @(negedge clk);
      chk("b2b_ready0", 128'(req_ready[0]), 128'(1'b1));
      if (k >= 3) chk("b2b_valid", 128'(cdb_valid), 128'(1'b1));
      cyc();
    end
    req_valid = '0;
    @(negedge clk);
    chk("b2b_valid", 128'(cdb_valid), 128'(1'b1));
    cyc();
    @(negedge clk);
    chk("b2b_valid", 128'(cdb_valid), 128'(1'b1));
    cyc();
    @(negedge clk);
    chk("b2b_end", 128'(cdb_valid), 128'(1'b0));
    drain("b2b_drain");

    // ALU streaming while LSQ posts one result
    for (int k = 0; k < 6; k++) begin
      req_valid   = (k == 0) ? 4'b1001 : 4'b0001;
      req_data[0] = mk(6'd2, 32'h100 + 32'(k));
      if (k == 0) req_data[3] = mk(6'd33, 32'h3333);
`ifdef CDB_ARB_RR_EN
      if (k == 0) begin
        push(2'd3, req_data[3]);
        push(2'd0, req_data[0]);
      end else if (k >= 2) begin
        push(2'd0, req_data[0]);
      end
      exp_r0 = (k != 1);
      exp_r3 = 1'b1;
`else
      push(2'd0, req_data[0]);
      exp_r0 = 1'b1;
      exp_r3 = (k == 0);
`endif
      @(negedge clk);
      chk("cont_ready0", 128'(req_ready[0]), 128'(exp_r0));
      chk("cont_ready3", 128'(req_ready[3]), 128'(exp_r3));
`ifdef CDB_ARB_RR_EN
      if (k == 2) begin
        chk("rr_starve_valid", 128'(cdb_valid), 128'(1'b1));
        chk("rr_starve_idx", 128'(grant_idx), 128'(2'd3));
      end
`endif
      cyc();
    end
    req_valid = '0;
`ifndef CDB_ARB_RR_EN
    push(2'd3, req_data[3]);
    @(negedge clk);
    chk("cont_hold3", 128'(req_ready[3]), 128'(1'b0));
`endif
    cyc();
    @(negedge clk);
    chk("cont_free3", 128'(req_ready[3]), 128'(1'b1));
    drain("cont_drain");

    // Flush with MUL and DIV slots full: neither result may reach the bus
    req_valid   = 4'b0110;
    req_data[1] = mk(6'd41, 32'h4141_0001);
    req_data[2] = mk(6'd42, 32'h4242_0002);
    cyc();
    req_valid   = 4'b0001;
    req_data[0] = mk(6'd40, 32'h4040);
    flush       = 1'b1;
    @(negedge clk);
    chk("flush_ready", 128'(req_ready), 128'(4'b1001));
    cyc();
    flush     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("flush_valid", 128'(cdb_valid), 128'(1'b0));
    chk("flush_ready_after", 128'(req_ready), 128'(4'hF));
    cyc();
    @(negedge clk);
    chk("flush_quiet", 128'(cdb_valid), 128'(1'b0));
    cyc();

`ifdef CDB_ARB_RR_EN
    all4("post_flush", 2'd1, 8'hB0);
`else
    all4("post_flush", 2'd0, 8'hB0);
`endif

    // Reset and flush together while a grant is pending
    req_valid   = 4'b0101;
    req_data[0] = mk(6'd50, 32'h5050);
    req_data[2] = mk(6'd52, 32'h5252);
    cyc();
    req_valid = '0;
    rst       = 1'b1;
    flush     = 1'b1;
    cyc();
    rst   = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("rstfl_valid", 128'(cdb_valid), 128'(1'b0));
    chk("rstfl_idx", 128'(grant_idx), 128'(2'd0));
    chk("rstfl_ready", 128'(req_ready), 128'(4'hF));
    chk("rstfl_cdb_out", 128'(cdb_out), 128'(0));
    cyc();
    @(negedge clk);
    chk("rstfl_quiet", 128'(cdb_valid), 128'(1'b0));
    cyc();
    all4("post_rst", 2'd0, 8'hC0);

    drain("final_drain");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
